// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, the
// receiver state type and a helper for sizing FIFO occupancy counters.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    // An occupancy counter must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle; otherwise it is dropped.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Output is forced to zero while empty so the consumer never sees stale data.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, configurable frame format, sticky
// error flags and a show-ahead receive FIFO on a ready/valid interface.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic                               overrun,
    input  logic                               err_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    logic [1:0]           sync;
    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bad_parity;

    logic                 stop_sample;
    logic                 last_stop;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 par_bad_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];

    // Parity over data plus received parity bit: odd wants 1, even wants 0.
    assign par_bad_now = (PARITY == PAR_ODD) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});

    assign stop_sample = (state == ST_STOP) && (cnt == '0);
    assign last_stop   = stop_sample && (stop_idx == LAST_STOP);
    assign push        = last_stop && rx_s && !bad_parity;
    assign pop         = rx_ready && !fifo_empty;
    assign rx_valid    = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            bad_parity <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state      <= ST_START;
                        cnt        <= HALF_BIT;
                        bad_parity <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= FULL_BIT;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL_BIT;
                        if (bit_idx == LAST_BIT) begin
                            state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == '0) begin
                        bad_parity <= par_bad_now;
                        state      <= ST_STOP;
                        cnt        <= FULL_BIT;
                        stop_idx   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state <= ST_BREAK_WAIT;
                        end else if (stop_idx == LAST_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            cnt      <= FULL_BIT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= (last_stop && rx_s && bad_parity) || (parity_err && !err_clr);
            frame_err  <= (stop_sample && !rx_s) || (frame_err && !err_clr);
            overrun    <= (push && fifo_full && !pop) || (overrun && !err_clr);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .dout      (rx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
